// File: rtl/pll_phase_ctrl.sv
// Sequencer for PLL dynamic phase shifting: steps PHASE_STEP_N once per requested step with a gap.
// Define PLL_PHASE_LOCK_WAIT_EN to wait for PLL lock (with timeout) before reporting completion.
module pll_phase_ctrl #(
  parameter int STEP_GAP     = 4,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  input  logic       pll_lock,
  output logic [2:0] phase_sel,
  output logic       phase_dir,
  output logic       phase_step_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETUP     = 3'd1;
  localparam logic [2:0] STEP      = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] DONE      = 3'd5;
`ifdef PLL_PHASE_LOCK_WAIT_EN
  localparam logic [2:0] WAIT_LOCK = 3'd4;
  localparam logic [2:0] FINISH    = WAIT_LOCK;
  localparam logic [15:0] WAIT_LAST = 16'(LOCK_TIMEOUT - 1);
`else
  localparam logic [2:0] FINISH    = DONE;
`endif
  localparam logic [7:0] GAP_LAST  = 8'(STEP_GAP - 1);

  if (STEP_GAP < 1 || STEP_GAP > 255) begin : g_bad_step_gap
    $error("STEP_GAP out of range 1..255");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT out of range 1..65535");
  end

  logic [2:0] state_reg, state_next;
  logic [7:0] rem_reg, rem_next;
  logic [7:0] gap_cnt_reg, gap_cnt_next;
  logic       req_ready_reg;
  logic [2:0] phase_sel_reg;
  logic       phase_dir_reg;
  logic       phase_step_n_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       accept;
`ifdef PLL_PHASE_LOCK_WAIT_EN
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        err_flag_reg, err_flag_next;
  logic        err_reg;
`endif

  assign accept = req_valid && req_ready_reg && (state_reg == IDLE);

  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    gap_cnt_next = 8'd0;
`ifdef PLL_PHASE_LOCK_WAIT_EN
    wait_cnt_next = 16'd0;
    err_flag_next = err_flag_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          rem_next   = req_steps;
        end
      end
      SETUP: state_next = (rem_reg != 8'd0) ? STEP : FINISH;
      STEP: begin
        rem_next   = rem_reg - 8'd1;
        state_next = GAP;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = (rem_reg != 8'd0) ? STEP : FINISH;
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
`ifdef PLL_PHASE_LOCK_WAIT_EN
      WAIT_LOCK: begin
        if (pll_lock) begin
          state_next    = DONE;
          err_flag_next = 1'b0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = DONE;
          err_flag_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      rem_reg          <= 8'd0;
      gap_cnt_reg      <= 8'd0;
      req_ready_reg    <= 1'b0;
      phase_sel_reg    <= 3'd0;
      phase_dir_reg    <= 1'b0;
      phase_step_n_reg <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rem_reg          <= rem_next;
      gap_cnt_reg      <= gap_cnt_next;
      req_ready_reg    <= (state_reg == IDLE) && !accept && pll_lock;
      if (accept) begin
        phase_sel_reg <= req_sel;
        phase_dir_reg <= req_dir;
      end
      phase_step_n_reg <= (state_reg != STEP);
      busy_reg         <= (state_reg != IDLE);
      done_reg         <= (state_reg == DONE);
    end
  end

`ifdef PLL_PHASE_LOCK_WAIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 16'd0;
      err_flag_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      err_flag_reg <= err_flag_next;
      err_reg      <= (state_reg == DONE) && err_flag_reg;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign req_ready    = req_ready_reg;
  assign phase_sel    = phase_sel_reg;
  assign phase_dir    = phase_dir_reg;
  assign phase_step_n = phase_step_n_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomized self-checking bench for pll_phase_ctrl; expectations come from a timeline model
// (pulse cycles, done cycle, lock-wait outcome) derived from the request and the planned pll_lock trace.
module tb_pll_phase_ctrl;

  localparam int G = 4;
  localparam int T = 8;
`ifdef PLL_PHASE_LOCK_WAIT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_sel = 3'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       pll_lock = 1'b1;
  logic [2:0] phase_sel;
  logic       phase_dir;
  logic       phase_step_n;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  bit lock_plan [0:2047];

  pll_phase_ctrl #(.STEP_GAP(G), .LOCK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .pll_lock(pll_lock),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request and check every output on every cycle from acceptance (k=0) to k=done+1.
  // lock_mode: 0 lock high, 1 random lock during stepping, 2 late lock during the wait, 3 no lock.
  task automatic do_req(input int sel, input int dir, input int steps, input int lock_mode,
                        input bit garbage, input int exp_wait);
    int waited, w0, d, k;
    bit exp_err, pulse;
    pll_lock  = 1'b1;
    req_sel   = 3'(sel);
    req_dir   = 1'(dir);
    req_steps = 8'(steps);
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_wait >= 0) chk("ready_latency", waited, exp_wait);
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end

    // Plan pll_lock for every cycle, then derive the expected timeline from it.
    w0 = 1 + steps * (G + 1);
    for (int i = 0; i < 2048; i++) begin
      if (i < w0) lock_plan[i] = (lock_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else if (lock_mode == 3) lock_plan[i] = 1'b0;
      else lock_plan[i] = 1'b1;
    end
    if (lock_mode == 2) begin
      int late;
      late = $urandom_range(0, T + 2);
      for (int i = 0; i < late; i++) lock_plan[w0 + i] = 1'b0;
    end
    exp_err = 1'b0;
    d = 2 + steps * (G + 1);
    if (LOCK_EN) begin
      d = w0 + T + 1;
      exp_err = 1'b1;
      for (int j = T - 1; j >= 0; j--) begin
        if (lock_plan[w0 + j]) begin
          d = w0 + j + 2;
          exp_err = 1'b0;
        end
      end
    end

    @(posedge clk);
    for (k = 0; k <= d + 1; k++) begin
      @(negedge clk);
      pulse = (steps > 0) && (k >= 2) && ((k - 2) % (G + 1) == 0) && ((k - 2) / (G + 1) < steps);
      chk($sformatf("step_n k=%0d", k), phase_step_n, !pulse);
      chk($sformatf("busy k=%0d", k), busy, (k >= 1 && k <= d));
      chk($sformatf("done k=%0d", k), done, (k == d));
      chk($sformatf("err k=%0d", k), err, (k == d) ? exp_err : 1'b0);
      chk($sformatf("ready k=%0d", k), req_ready, (k <= d) ? 1'b0 : lock_plan[d]);
      chk($sformatf("sel k=%0d", k), phase_sel, sel);
      chk($sformatf("dir k=%0d", k), phase_dir, dir);
      pll_lock = lock_plan[k];
      if (garbage && k < d) begin
        req_valid = 1'($urandom_range(0, 1));
        req_sel   = 3'($urandom_range(0, 4));
        req_dir   = 1'($urandom_range(0, 1));
        req_steps = 8'($urandom_range(0, 255));
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    pll_lock  = 1'b1;
    @(negedge clk);
    $display("txn sel=%0d dir=%0d steps=%0d lock_mode=%0d busy_req=%0d done_at=%0d err=%0d",
             sel, dir, steps, lock_mode, garbage, d, exp_err);
  endtask

  // Reset in the gap after the second of five pulses.
  task automatic do_mid_reset();
    int pulses, late_pulses, late_done, late_busy;
    pll_lock  = 1'b1;
    req_sel   = 3'd3;
    req_dir   = 1'b1;
    req_steps = 8'd5;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("rst_test_ready", req_ready, 1);
    @(posedge clk);
    pulses = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!phase_step_n) pulses++;
    end
    chk("pulses_before_rst", pulses, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst step_n", phase_step_n, 1);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst ready", req_ready, 0);
    chk("mid_rst sel", phase_sel, 0);
    rst = 1'b0;
    late_pulses = 0; late_done = 0; late_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!phase_step_n) late_pulses++;
      if (done) late_done++;
      if (busy) late_busy++;
    end
    chk("post_rst pulses", late_pulses, 0);
    chk("post_rst done", late_done, 0);
    chk("post_rst busy", late_busy, 0);
    chk("post_rst ready", req_ready, 1);
    $display("txn mid-sequence reset steps=5 pulses_before=%0d pulses_after=%0d", pulses, late_pulses);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst ready", req_ready, 0);
    chk("rst sel", phase_sel, 0);
    chk("rst dir", phase_dir, 0);
    chk("rst step_n", phase_step_n, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", req_ready, 1);

    do_req(2, 1, 3, 0, 1'b0, 0);
    do_req(1, 0, 0, 0, 1'b0, 0);

    // Request held while unlocked must stall, then be taken once lock returns.
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_sel = 3'd4; req_dir = 1'b0; req_steps = 8'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("unlocked ready", req_ready, 0);
      chk("unlocked busy", busy, 0);
    end
    do_req(4, 0, 2, 0, 1'b0, 1);

    do_mid_reset();
    do_req(3, 1, 4, 1, 1'b1, 0);
    do_req(0, 1, 2, 3, 1'b0, 0);
    do_req(2, 0, 1, 2, 1'b0, -1);
    do_req(4, 1, 255, 0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      do_req($urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 12),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
